pc_gen_btb: RTL and testbench
=============================

# pc_gen_btb

Parametrised instruction-fetch PC generator for the IF stage. It produces the fetch address for a synchronous instruction ROM and the PC of the instruction currently returned to ID. It arbitrates prioritised redirects (trap flush, resolved branch) against stall. A direct-mapped branch target buffer (BTB), trained by the resolve stage, predicts taken branches at fetch.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width in bits
- DATA_WIDTH, 32, ROM data width; rom_write_en width is DATA_WIDTH/8
- INIT_PC, 32'h0000_0000, first fetched address after reset
- INST_BYTES, 4, instruction size in bytes (power of 2)
- BTB_DEPTH, 16, BTB entries (power of 2, ≥2); IDX_W = log2(BTB_DEPTH), OFF_W = log2(INST_BYTES)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- stall_pc  in  1  hold PC and fetch address
- flush  in  1  trap/exception redirect, highest priority
- flush_addr  in  ADDR_WIDTH  flush target
- branch_flag  in  1  resolved-branch redirect (mispredict correction)
- branch_addr  in  ADDR_WIDTH  branch redirect target
- upd_valid  in  1  BTB training request
- upd_pc  in  ADDR_WIDTH  PC of resolved branch
- upd_target  in  ADDR_WIDTH  resolved target
- upd_taken  in  1  1 = allocate/overwrite entry, 0 = invalidate on tag match
- pc  out  ADDR_WIDTH  PC of instruction whose ROM data is valid this cycle
- pred_taken  out  1  BTB hit on current pc selected next_pc
- rom_en  out  1  ROM read enable
- rom_write_en  out  DATA_WIDTH/8  tied 0
- rom_addr  out  ADDR_WIDTH  = next_pc (combinational)
- rom_write_data  out  DATA_WIDTH  tied 0

## Operation
- Registers: pc, rom_en, BTB arrays valid[BTB_DEPTH], tag[BTB_DEPTH], target[BTB_DEPTH].
- Index = addr[OFF_W+IDX_W-1:OFF_W]. Tag = addr[ADDR_WIDTH-1:OFF_W+IDX_W].
- hit = rom_en & valid[idx(pc)] & (tag[idx(pc)] == tag(pc)).
- next_pc is chosen by the first matching rule:
  1. rom_en==0 → pc+INST_BYTES
  2. flush → flush_addr
  3. branch_flag → branch_addr
  4. stall_pc → pc
  5. hit → target[idx(pc)]
  6. otherwise → pc+INST_BYTES
- Redirects override stall_pc; the requester owns the pipeline flush.
- pred_taken = hit & !flush & !branch_flag & !stall_pc.
- Redirect addresses and BTB targets have their low OFF_W bits forced to 0.
- pc+INST_BYTES wraps modulo 2^ADDR_WIDTH.
- pc register: on rst it loads INIT_PC-INST_BYTES (mod 2^ADDR_WIDTH). Otherwise it loads next_pc when rom_en==1, and holds when rom_en==0.
- rom_en register: 0 on rst, else 1.
- BTB update applies on the edge where upd_valid==1:
  - taken: valid/tag/target[idx(upd_pc)] ← 1 / tag(upd_pc) / aligned upd_target.
  - not-taken: valid[idx(upd_pc)] ← 0 only if that entry's tag equals tag(upd_pc).
  - Updates are applied even while stalled.
- rst clears all valid bits and has priority over upd_valid.
- Aliasing PCs with the same index evict each other. There is no replacement state.

## Timing
- Reset values: pc = INIT_PC-INST_BYTES, rom_en = 0, pred_taken = 0, all BTB valid = 0.
- rom_addr = INIT_PC throughout the reset phase.
- First edge with rst=0 sets rom_en=1 while pc holds. rom_addr = INIT_PC is therefore fetched in that cycle, and pc = INIT_PC one cycle later.
- Redirect asserted in cycle t: rom_addr = target in cycle t; pc = target in t+1.
- Predicted branch: hit in cycle t gives rom_addr = BTB target in t.
- BTB read is read-before-write. An update at edge e is visible to lookups only from the cycle after e.
- rst asserted mid-operation: on the next edge all state returns to its reset values, regardless of stall, flush or update.

## Test plan
- Reset release (INIT_PC=0): rst high 3 cycles then low → pc=0xFFFFFFFC with rom_en=0; rom_en=1 after first rst=0 edge; rom_addr 0x0,0x4,0x8; pc 0x0,0x4 on following cycles.
- Stall: stall_pc=1 for 3 cycles at pc=0x8 → pc=0x8, rom_addr=0x8 throughout; after release rom_addr=0xC, then pc=0xC.
- Priority: stall_pc=1, flush=1 flush_addr=0x200, branch_flag=1 branch_addr=0x300 in the same cycle → rom_addr=0x200, next pc=0x200, pred_taken=0.
- BTB train/predict: upd taken pc=0x10 target=0x80. Sequential fetch reaches pc=0x10 → pred_taken=1, rom_addr=0x80. Then upd not-taken pc=0x10 → next visit rom_addr=0x14, pred_taken=0.
- Aliasing (BTB_DEPTH=16): entry for 0x10 valid; pc=0x50 → no hit, rom_addr=0x54. Not-taken update for 0x50 leaves the 0x10 entry valid.
- Wrap/alignment: branch_addr=0xFFFFFFFC → pc then 0x0; flush_addr=0x103 → rom_addr=0x100. upd_valid together with rst → entry stays invalid.

Source files
------------

// File: rtl/pc_gen_btb.sv
// IF-stage PC generator: prioritised flush/branch/stall redirects plus a
// direct-mapped BTB that predicts taken branches at fetch time.
module pc_gen_btb #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] INIT_PC    = '0,
    parameter int                    INST_BYTES = 4,
    parameter int                    BTB_DEPTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall_pc,
    input  logic                    flush,
    input  logic [ADDR_WIDTH-1:0]   flush_addr,
    input  logic                    branch_flag,
    input  logic [ADDR_WIDTH-1:0]   branch_addr,
    input  logic                    upd_valid,
    input  logic [ADDR_WIDTH-1:0]   upd_pc,
    input  logic [ADDR_WIDTH-1:0]   upd_target,
    input  logic                    upd_taken,
    output logic [ADDR_WIDTH-1:0]   pc,
    output logic                    pred_taken,
    output logic                    rom_en,
    output logic [DATA_WIDTH/8-1:0] rom_write_en,
    output logic [ADDR_WIDTH-1:0]   rom_addr,
    output logic [DATA_WIDTH-1:0]   rom_write_data
);
    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int OFF_W = $clog2(INST_BYTES);
    localparam int TAG_W = ADDR_WIDTH - OFF_W - IDX_W;

    localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(INST_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(INST_BYTES - 1));

    logic [BTB_DEPTH-1:0]                 btb_valid;
    logic [BTB_DEPTH-1:0][TAG_W-1:0]      btb_tag;
    logic [BTB_DEPTH-1:0][ADDR_WIDTH-1:0] btb_target;

    logic [IDX_W-1:0]      pc_idx, upd_idx;
    logic [TAG_W-1:0]      pc_tag, upd_tag;
    logic [ADDR_WIDTH-1:0] pc_inc, next_pc;
    logic                  hit;

    assign pc_idx  = pc[OFF_W +: IDX_W];
    assign pc_tag  = pc[ADDR_WIDTH-1 -: TAG_W];
    assign upd_idx = upd_pc[OFF_W +: IDX_W];
    assign upd_tag = upd_pc[ADDR_WIDTH-1 -: TAG_W];
    assign pc_inc  = pc + STEP;

    assign hit        = rom_en & btb_valid[pc_idx] & (btb_tag[pc_idx] == pc_tag);
    assign pred_taken = hit & ~flush & ~branch_flag & ~stall_pc;

    // rom_en==0 only in the cycle after reset, where pc+STEP yields INIT_PC.
    always_comb begin
        next_pc = pc_inc;
        if (!rom_en)          next_pc = pc_inc;
        else if (flush)       next_pc = flush_addr & ALIGN_MASK;
        else if (branch_flag) next_pc = branch_addr & ALIGN_MASK;
        else if (stall_pc)    next_pc = pc;
        else if (hit)         next_pc = btb_target[pc_idx];
    end

    assign rom_addr       = next_pc;
    assign rom_write_en   = '0;
    assign rom_write_data = '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= INIT_PC - STEP;
            rom_en <= 1'b0;
        end else begin
            rom_en <= 1'b1;
            if (rom_en) pc <= next_pc;
        end
    end

    // Lookups above see the pre-edge contents, so an update is visible next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            btb_valid <= '0;
        end else if (upd_valid) begin
            if (upd_taken) begin
                btb_valid[upd_idx]  <= 1'b1;
                btb_tag[upd_idx]    <= upd_tag;
                btb_target[upd_idx] <= upd_target & ALIGN_MASK;
            end else if (btb_tag[upd_idx] == upd_tag) begin
                btb_valid[upd_idx] <= 1'b0;
            end
        end
    end

    generate
        if (OFF_W > 0) begin : g_unused
            logic unused_upd_lsb;
            assign unused_upd_lsb = ^upd_pc[OFF_W-1:0];
        end
    endgenerate
endmodule

// File: tb/tb_pc_gen_btb.sv
// Directed bench for pc_gen_btb: expectations queued as each step is driven,
// popped and compared on the following negedge.
module tb_pc_gen_btb;
    localparam int SIG_PC = 0, SIG_RA = 1, SIG_PT = 2, SIG_EN = 3, SIG_WE = 4, SIG_WD = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_pc = 1'b0, flush = 1'b0, branch_flag = 1'b0;
    logic [31:0] flush_addr = '0, branch_addr = '0;
    logic        upd_valid = 1'b0, upd_taken = 1'b0;
    logic [31:0] upd_pc = '0, upd_target = '0;
    logic [31:0] pc, rom_addr, rom_write_data;
    logic        pred_taken, rom_en;
    logic [3:0]  rom_write_en;

    pc_gen_btb #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .INIT_PC(32'h0),
        .INST_BYTES(4), .BTB_DEPTH(16)
    ) dut (
        .clk(clk), .rst(rst), .stall_pc(stall_pc),
        .flush(flush), .flush_addr(flush_addr),
        .branch_flag(branch_flag), .branch_addr(branch_addr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_taken(upd_taken),
        .pc(pc), .pred_taken(pred_taken), .rom_en(rom_en),
        .rom_write_en(rom_write_en), .rom_addr(rom_addr),
        .rom_write_data(rom_write_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sig;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string n, input int s, input logic [31:0] v);
        exp_t e;
        e.name = n; e.sig = s; e.val = v;
        sb.push_back(e);
    endtask

    task automatic expect_cyc(input string n, input logic [31:0] p,
                              input logic [31:0] ra, input logic pt, input logic en);
        push({n, ".pc"}, SIG_PC, p);
        push({n, ".rom_addr"}, SIG_RA, ra);
        push({n, ".pred_taken"}, SIG_PT, {31'b0, pt});
        push({n, ".rom_en"}, SIG_EN, {31'b0, en});
    endtask

    // Compare everything queued for this cycle, then advance past the next edge.
    task automatic cyc();
        exp_t        e;
        logic [31:0] obs;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sig)
                SIG_PC:  obs = pc;
                SIG_RA:  obs = rom_addr;
                SIG_PT:  obs = {31'b0, pred_taken};
                SIG_EN:  obs = {31'b0, rom_en};
                SIG_WE:  obs = {28'b0, rom_write_en};
                default: obs = rom_write_data;
            endcase
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.name, obs, e.val);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        expect_cyc("rst", 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0);
        push("rst.rom_write_en", SIG_WE, 32'h0);
        push("rst.rom_write_data", SIG_WD, 32'h0);
        cyc();
        rst = 1'b0;
        expect_cyc("rel0", 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0); cyc();
        expect_cyc("rel1", 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b1); cyc();
        expect_cyc("seq0", 32'h0, 32'h4, 1'b0, 1'b1); cyc();
        expect_cyc("seq1", 32'h4, 32'h8, 1'b0, 1'b1); cyc();

        // Stall at 0x8
        stall_pc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_cyc("stall", 32'h8, 32'h8, 1'b0, 1'b1); cyc();
        end
        stall_pc = 1'b0;
        expect_cyc("unstall", 32'h8, 32'hC, 1'b0, 1'b1); cyc();

        // Train 0x10 -> 0x80 while pc=0xC
        upd_valid = 1'b1; upd_taken = 1'b1; upd_pc = 32'h10; upd_target = 32'h80;
        expect_cyc("train", 32'hC, 32'h10, 1'b0, 1'b1); cyc();
        upd_valid = 1'b0;
        expect_cyc("pred", 32'h10, 32'h80, 1'b1, 1'b1); cyc();

        // Train entry for 0x80 during its own lookup: not visible this cycle
        upd_valid = 1'b1; upd_taken = 1'b1; upd_pc = 32'h80; upd_target = 32'h40;
        expect_cyc("rbw", 32'h80, 32'h84, 1'b0, 1'b1); cyc();
        upd_valid = 1'b0;

        // Alias 0x50 shares index with 0x10
        branch_flag = 1'b1; branch_addr = 32'h50;
        expect_cyc("br50", 32'h84, 32'h50, 1'b0, 1'b1); cyc();
        branch_flag = 1'b0;
        upd_valid = 1'b1; upd_taken = 1'b0; upd_pc = 32'h50;
        expect_cyc("alias", 32'h50, 32'h54, 1'b0, 1'b1); cyc();
        upd_valid = 1'b0;
        branch_flag = 1'b1; branch_addr = 32'h10;
        expect_cyc("br10", 32'h54, 32'h10, 1'b0, 1'b1); cyc();
        branch_flag = 1'b0;
        // Entry survived the aliased invalidate; invalidate it for real now
        upd_valid = 1'b1; upd_taken = 1'b0; upd_pc = 32'h10;
        expect_cyc("alias_kept", 32'h10, 32'h80, 1'b1, 1'b1); cyc();
        upd_valid = 1'b0;
        expect_cyc("pred80", 32'h80, 32'h40, 1'b1, 1'b1); cyc();
        branch_flag = 1'b1; branch_addr = 32'h10;
        expect_cyc("nohit40", 32'h40, 32'h10, 1'b0, 1'b1); cyc();
        branch_flag = 1'b0;
        expect_cyc("inval", 32'h10, 32'h14, 1'b0, 1'b1); cyc();

        // Priority: flush > branch > stall
        stall_pc = 1'b1; flush = 1'b1; flush_addr = 32'h200;
        branch_flag = 1'b1; branch_addr = 32'h300;
        expect_cyc("prio", 32'h14, 32'h200, 1'b0, 1'b1); cyc();
        stall_pc = 1'b0; flush = 1'b0;
        branch_addr = 32'hFFFF_FFFC;
        expect_cyc("br_wrap", 32'h200, 32'hFFFF_FFFC, 1'b0, 1'b1); cyc();
        branch_flag = 1'b0;
        expect_cyc("wrap", 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b1); cyc();
        flush = 1'b1; flush_addr = 32'h103;
        expect_cyc("fl_align", 32'h0, 32'h100, 1'b0, 1'b1); cyc();
        flush = 1'b0;

        // Misaligned BTB target gets aligned; stall suppresses prediction
        upd_valid = 1'b1; upd_taken = 1'b1; upd_pc = 32'h104; upd_target = 32'h2A2;
        expect_cyc("train104", 32'h100, 32'h104, 1'b0, 1'b1); cyc();
        upd_valid = 1'b0;
        stall_pc = 1'b1;
        expect_cyc("stall_hit", 32'h104, 32'h104, 1'b0, 1'b1); cyc();
        stall_pc = 1'b0;
        expect_cyc("tgt_align", 32'h104, 32'h2A0, 1'b1, 1'b1); cyc();

        // Reset mid-run with a concurrent taken update
        rst = 1'b1;
        upd_valid = 1'b1; upd_taken = 1'b1; upd_pc = 32'h2A0; upd_target = 32'h500;
        expect_cyc("pre_rst", 32'h2A0, 32'h2A4, 1'b0, 1'b1); cyc();
        rst = 1'b0; upd_valid = 1'b0;
        expect_cyc("mid_rst", 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0); cyc();
        branch_flag = 1'b1; branch_addr = 32'h2A0;
        expect_cyc("post_rst", 32'hFFFF_FFFC, 32'h2A0, 1'b0, 1'b1); cyc();
        branch_addr = 32'h104;
        expect_cyc("rst_upd_dropped", 32'h2A0, 32'h104, 1'b0, 1'b1); cyc();
        branch_flag = 1'b0;
        expect_cyc("rst_cleared", 32'h104, 32'h108, 1'b0, 1'b1); cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
